// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths and the opcode encoding used by the ALU
// and by every requester that drives it.
package alu_pkg;

   localparam int WIDTH = 32;
   localparam int OP_W  = 4;

   typedef enum logic [OP_W-1:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_SLL  = 4'b0010,
      ALU_SLT  = 4'b0100,
      ALU_SLTU = 4'b0110,
      ALU_XOR  = 4'b1000,
      ALU_SRL  = 4'b1010,
      ALU_SRA  = 4'b1011,
      ALU_OR   = 4'b1100,
      ALU_AND  = 4'b1110
   } alu_op_e;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; shift amounts use the full B operand and
// unknown opcodes produce zero.
module alu
   import alu_pkg::*;
(
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [OP_W-1:0]  op_i,
   output logic [WIDTH-1:0] res_o
);

   always_comb begin
      res_o = '0;
      case (op_i)
         ALU_ADD:  res_o = a_i + b_i;
         ALU_SUB:  res_o = a_i - b_i;
         ALU_SLL:  res_o = a_i << b_i;
         ALU_SLT:  res_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         ALU_SLTU: res_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
         ALU_XOR:  res_o = a_i ^ b_i;
         ALU_SRL:  res_o = a_i >> b_i;
         ALU_SRA:  res_o = $unsigned($signed(a_i) >>> b_i);
         ALU_OR:   res_o = a_i | b_i;
         ALU_AND:  res_o = a_i & b_i;
         default:  res_o = '0;
      endcase
   end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational; on contention the requester
// that did not win last time is chosen.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two requesters; result is registered, 1-cycle latency.
// A stalled result blocks new accepts; a draining result can be refilled in the same cycle.
module alu_share_arbiter #(
   parameter int WIDTH = alu_pkg::WIDTH,
   parameter int OP_W  = alu_pkg::OP_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req_a0,
   input  logic [WIDTH-1:0] req_a1,
   input  logic [WIDTH-1:0] req_b0,
   input  logic [WIDTH-1:0] req_b1,
   input  logic [OP_W-1:0]  req_op0,
   input  logic [OP_W-1:0]  req_op1,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic [15:0]      busy_cnt
);
   import alu_pkg::*;

   logic             out_valid_q, out_valid_d;
   logic             out_owner_q, out_owner_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic             last_grant_q, last_grant_d;
   logic [15:0]      busy_cnt_q,  busy_cnt_d;

   logic             can_issue;
   logic             stall;
   logic             accept;
   logic             gnt_idx;
   logic [1:0]       grant;
   logic [WIDTH-1:0] alu_a, alu_b, alu_res;
   logic [OP_W-1:0]  alu_op;

   rr_arb2 u_arb (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .grant      (grant)
   );

   // Capacity comes only from the output register state, never from the data path.
   assign can_issue = !out_valid_q || rsp_ready[out_owner_q];
   assign stall     = out_valid_q && !rsp_ready[out_owner_q];
   assign req_ready = (rst_n && can_issue) ? grant : 2'b00;
   assign accept    = |(req_valid & req_ready);
   assign gnt_idx   = grant[1];

   assign alu_a  = gnt_idx ? req_a1  : req_a0;
   assign alu_b  = gnt_idx ? req_b1  : req_b0;
   assign alu_op = gnt_idx ? req_op1 : req_op0;

   alu u_alu (
      .a_i   (alu_a),
      .b_i   (alu_b),
      .op_i  (alu_op),
      .res_o (alu_res)
   );

   always_comb begin
      out_valid_d  = out_valid_q;
      out_owner_d  = out_owner_q;
      out_data_d   = out_data_q;
      last_grant_d = last_grant_q;
      busy_cnt_d   = busy_cnt_q;
      if (accept) begin
         out_valid_d  = 1'b1;
         out_owner_d  = gnt_idx;
         out_data_d   = alu_res;
         last_grant_d = gnt_idx;
      end else if (out_valid_q && rsp_ready[out_owner_q]) begin
         out_valid_d = 1'b0;
      end
      if (stall && (busy_cnt_q != 16'hFFFF)) begin
         busy_cnt_d = busy_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_owner_q  <= 1'b0;
         out_data_q   <= '0;
         last_grant_q <= 1'b1;
         busy_cnt_q   <= 16'd0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_owner_q  <= out_owner_d;
         out_data_q   <= out_data_d;
         last_grant_q <= last_grant_d;
         busy_cnt_q   <= busy_cnt_d;
      end
   end

   assign rsp_valid = out_valid_q ? (out_owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_data  = out_data_q;
   assign busy_cnt  = busy_cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: vector table plus hand sequences for
// backpressure, reset mid-operation and idle behaviour.
module tb_alu_share_arbiter;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_SLL  = 4'b0010;
   localparam logic [3:0] OP_SLT  = 4'b0100;
   localparam logic [3:0] OP_SLTU = 4'b0110;
   localparam logic [3:0] OP_XOR  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1010;
   localparam logic [3:0] OP_SRA  = 4'b1011;
   localparam logic [3:0] OP_OR   = 4'b1100;
   localparam logic [3:0] OP_AND  = 4'b1110;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] req_a0, req_a1, req_b0, req_b1;
   logic [3:0]  req_op0, req_op1;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [31:0] rsp_data;
   logic [15:0] busy_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_share_arbiter #(.WIDTH(32), .OP_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a0    (req_a0),
      .req_a1    (req_a1),
      .req_b0    (req_b0),
      .req_b1    (req_b1),
      .req_op0   (req_op0),
      .req_op1   (req_op1),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .busy_cnt  (busy_cnt)
   );

   typedef struct {
      logic [1:0]  rv;
      logic [1:0]  rr;
      logic [31:0] a0;
      logic [31:0] b0;
      logic [3:0]  op0;
      logic [31:0] a1;
      logic [31:0] b1;
      logic [3:0]  op1;
      logic [1:0]  exp_rdy;
      logic [1:0]  exp_vld;
      logic [31:0] exp_dat;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] held_data;
      logic [15:0] held_busy;

      vecs[0]  = '{2'b01, 2'b11, 32'd5, 32'd7, OP_ADD, 32'd0, 32'd0, OP_ADD, 2'b01, 2'b01, 32'd12};
      vecs[1]  = '{2'b10, 2'b11, 32'd0, 32'd0, OP_ADD, 32'hFF00FF00, 32'h0FF00FF0, OP_AND, 2'b10, 2'b10, 32'h0F000F00};
      vecs[2]  = '{2'b11, 2'b11, 32'd10, 32'd3, OP_SUB, 32'hF0, 32'h0F, OP_XOR, 2'b01, 2'b01, 32'd7};
      vecs[3]  = '{2'b11, 2'b11, 32'hFFFFFFFF, 32'd1, OP_SLT, 32'hF0, 32'h0F, OP_XOR, 2'b10, 2'b10, 32'hFF};
      vecs[4]  = '{2'b11, 2'b11, 32'hFFFFFFFF, 32'd1, OP_SLT, 32'hFFFFFFFF, 32'd1, OP_SLTU, 2'b01, 2'b01, 32'd1};
      vecs[5]  = '{2'b11, 2'b11, 32'd1, 32'd1, OP_ADD, 32'hFFFFFFFF, 32'd1, OP_SLTU, 2'b10, 2'b10, 32'd0};
      vecs[6]  = '{2'b01, 2'b11, 32'h80000000, 32'd4, OP_SRA, 32'd0, 32'd0, OP_ADD, 2'b01, 2'b01, 32'hF8000000};
      vecs[7]  = '{2'b01, 2'b11, 32'h80000000, 32'd4, OP_SRL, 32'd0, 32'd0, OP_ADD, 2'b01, 2'b01, 32'h08000000};
      vecs[8]  = '{2'b10, 2'b11, 32'd0, 32'd0, OP_ADD, 32'd123, 32'd456, 4'b0011, 2'b10, 2'b10, 32'd0};
      vecs[9]  = '{2'b01, 2'b11, 32'd1, 32'd33, OP_SLL, 32'd0, 32'd0, OP_ADD, 2'b01, 2'b01, 32'd0};
      vecs[10] = '{2'b01, 2'b11, 32'd1, 32'd4, OP_SLL, 32'd0, 32'd0, OP_ADD, 2'b01, 2'b01, 32'd16};
      vecs[11] = '{2'b10, 2'b11, 32'd0, 32'd0, OP_ADD, 32'hF0F0, 32'h0FF0, OP_OR, 2'b10, 2'b10, 32'hFFF0};
      vecs[12] = '{2'b00, 2'b11, 32'd0, 32'd0, OP_ADD, 32'd0, 32'd0, OP_ADD, 2'b00, 2'b00, 32'd0};

      // Reset with a request already pending: nothing may be accepted.
      rst_n = 1'b0; req_valid = 2'b01; rsp_ready = 2'b11;
      req_a0 = 32'd1; req_b0 = 32'd1; req_op0 = OP_ADD;
      req_a1 = 32'd0; req_b1 = 32'd0; req_op1 = OP_ADD;
      step();
      step();
      chk("reset_req_ready", 32'(req_ready), 32'(2'b00));
      chk("reset_rsp_valid", 32'(rsp_valid), 32'(2'b00));
      chk("reset_rsp_data", rsp_data, 32'd0);
      chk("reset_busy_cnt", 32'(busy_cnt), 32'd0);
      req_valid = 2'b00;
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 13; i++) begin
         req_valid = vecs[i].rv;  rsp_ready = vecs[i].rr;
         req_a0 = vecs[i].a0; req_b0 = vecs[i].b0; req_op0 = vecs[i].op0;
         req_a1 = vecs[i].a1; req_b1 = vecs[i].b1; req_op1 = vecs[i].op1;
         #1;
         chk($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].exp_rdy));
         step();
         chk($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].exp_vld));
         if (vecs[i].exp_vld != 2'b00)
            chk($sformatf("vec%0d_rsp_data", i), rsp_data, vecs[i].exp_dat);
      end
      chk("table_busy_cnt", 32'(busy_cnt), 32'd0);

      // Backpressure: requester 0 result stalls for 3 cycles while requester 1 waits.
      req_valid = 2'b01; rsp_ready = 2'b11;
      req_a0 = 32'h1234; req_b0 = 32'h10; req_op0 = OP_ADD;
      step();
      req_valid = 2'b10; rsp_ready = 2'b00;
      req_a1 = 32'd2; req_b1 = 32'd3; req_op1 = OP_ADD;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("stall%0d_req_ready", k), 32'(req_ready), 32'(2'b00));
         chk($sformatf("stall%0d_rsp_valid", k), 32'(rsp_valid), 32'(2'b01));
         chk($sformatf("stall%0d_rsp_data", k), rsp_data, 32'h1244);
         step();
      end
      chk("stall_busy_cnt", 32'(busy_cnt), 32'd3);
      rsp_ready = 2'b01;
      #1;
      chk("refill_req_ready", 32'(req_ready), 32'(2'b10));
      step();
      chk("refill_rsp_valid", 32'(rsp_valid), 32'(2'b10));
      chk("refill_rsp_data", rsp_data, 32'd5);
      chk("refill_busy_cnt", 32'(busy_cnt), 32'd3);
      req_valid = 2'b00; rsp_ready = 2'b11;
      step();
      chk("drain_rsp_valid", 32'(rsp_valid), 32'(2'b00));

      // Reset while a requester-1 result is stalled.
      req_valid = 2'b10; req_a1 = 32'd1; req_b1 = 32'd1; req_op1 = OP_ADD;
      step();
      req_valid = 2'b00; rsp_ready = 2'b00;
      step();
      chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'(2'b10));
      chk("pre_rst_busy_cnt", 32'(busy_cnt), 32'd4);
      rst_n = 1'b0;
      step();
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'(2'b00));
      chk("mid_rst_busy_cnt", 32'(busy_cnt), 32'd0);
      rst_n = 1'b1; rsp_ready = 2'b11; req_valid = 2'b11;
      req_a0 = 32'd40; req_b0 = 32'd2; req_op0 = OP_ADD;
      req_a1 = 32'd9;  req_b1 = 32'd9; req_op1 = OP_ADD;
      #1;
      chk("post_rst_req_ready", 32'(req_ready), 32'(2'b01));
      step();
      chk("post_rst_rsp_valid", 32'(rsp_valid), 32'(2'b01));
      chk("post_rst_rsp_data", rsp_data, 32'd42);

      // Idle: nothing changes, and priority stays with requester 1 afterwards.
      req_valid = 2'b00;
      step();
      held_busy = busy_cnt;
      held_data = rsp_data;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("idle%0d_rsp_valid", k), 32'(rsp_valid), 32'(2'b00));
         chk($sformatf("idle%0d_busy_cnt", k), 32'(busy_cnt), 32'(held_busy));
         step();
      end
      chk("idle_data_hold", rsp_data, held_data);
      req_valid = 2'b11;
      #1;
      chk("idle_last_grant", 32'(req_ready), 32'(2'b10));
      step();
      chk("idle_after_rsp_data", rsp_data, 32'd18);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU instance between two requesters, e.g. the execute stage and a helper unit such as an address or branch-compare path.
- Round-robin arbitration with a valid/ready handshake on both the request and response sides.
- A single-entry registered result buffer returns the result one cycle after acceptance, at full throughput when the response side is not stalled.
- Sits between the issue logic and the existing ALU in the simple pipeline.

Parameters:
- WIDTH, 32, operand and result width; must match the ALU (32).
- OP_W, 4, alu_op field width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  2  per-requester request valid; bit i belongs to requester i.
- req_ready  out  2  per-requester accept; a request is accepted when req_valid[i] && req_ready[i].
- req_a0, req_a1  in  WIDTH  operand A for requester 0 / 1.
- req_b0, req_b1  in  WIDTH  operand B for requester 0 / 1.
- req_op0, req_op1  in  OP_W  ALU opcode for requester 0 / 1.
- rsp_valid  out  2  result valid for requester i.
- rsp_ready  in  2  requester i consumes its result.
- rsp_data  out  WIDTH  result data, shared bus; meaningful only when a rsp_valid bit is high.
- busy_cnt  out  16  saturating count of cycles in which a result was stalled (rsp_valid && !rsp_ready).

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low; it samples rst_n low on a rising clk edge.
- Registered state:
  - out_valid, out_owner (1 b), out_data (WIDTH).
  - last_grant (1 b).
  - busy_cnt.
- Reset values:
  - out_valid=0, out_owner=0, out_data=0, busy_cnt=0.
  - last_grant=1, so requester 0 has priority first.
  - Outputs: rsp_valid=00, rsp_data=0, busy_cnt=0.
  - req_ready is forced to 00 while rst_n=0.
- Capacity:
  - can_issue = !out_valid || rsp_ready[out_owner].
  - This gives drain-and-refill in the same cycle.
- Grant (combinational):
  - If only one req_valid bit is set, that requester is granted.
  - If both are set, the requester != last_grant is granted.
  - If none are set, there is no grant.
- Handshakes:
  - req_ready[g] = can_issue for the granted g; the other bit is 0.
  - req_ready must not depend on rsp_data.
- On accept (cycle N):
  - The ALU is driven with the granted A, B and op.
  - out_data <= ALU result, out_owner <= g, out_valid <= 1, last_grant <= g.
  - rsp_valid[g] rises at cycle N+1. Latency is exactly 1 cycle.
- On drain without new accept: out_valid <= 0.
- Response side:
  - rsp_valid[i] = out_valid && out_owner==i. At most one bit is set.
  - rsp_data = out_data.
- Stall: while rsp_valid[i] && !rsp_ready[i], out_data and out_owner hold stable and no new request is accepted.
- busy_cnt increments on each stall cycle and saturates at 0xFFFF.
- Operands and opcode pass to the ALU unmodified; the arbiter does no masking or decoding.
  - Undefined opcodes yield 0 from the ALU.
  - Shifts use the full B value.
- Requester protocol:
  - After asserting req_valid, a requester must hold it and its operands stable until accepted.
  - A requester may retract its request only while its req_ready=0. This is allowed; the arbiter keeps no per-request state before acceptance.
- Reset mid-operation: a pending result is discarded; rsp_valid goes to 00 after that edge, and priority returns to requester 0.
- No starvation: with both requesters continuously valid and rsp_ready=11, grants strictly alternate.

Decomposition:
- Shared package alu_pkg:
  - alu_op_e enum: ADD 0000, SUB 0001, SLL 0010, SLT 0100, SLTU 0110, XOR 1000, SRL 1010, SRA 1011, OR 1100, AND 1110.
  - WIDTH and OP_W constants.
- Sub-module rr_arb2: a 2-way round-robin grant with inputs req[1:0] and last_grant and output grant one-hot.
- The ALU is instantiated once inside alu_share_arbiter.

Test Plan:
- Single request: req_valid=01, a0=5, b0=7, op=ADD -> req_ready=01 same cycle; next cycle rsp_valid=01, rsp_data=12.
- Contention: req_valid=11 held 4 accepts, rsp_ready=11, distinct ops (SUB 10-3, XOR 0xF0^0x0F, SLT -1<1, SLTU 0xFFFFFFFF<1) -> grants 0,1,0,1. Responses 7, 0xFF, 1, 0 on consecutive cycles, owners alternating.
- Backpressure: result owned by requester 0 with rsp_ready=00 for 3 cycles while req_valid=10 -> req_ready=00. rsp_data is stable. busy_cnt=3. Raising rsp_ready[0] accepts requester 1 in that same cycle.
- Opcodes: SRA a=0x80000000, b=4 -> 0xF8000000. SRL same operands -> 0x08000000. Opcode 0011 -> 0.
- Reset mid-operation: rsp_valid=10 pending with rsp_ready=00, then rst_n=0 for one edge -> rsp_valid=00, busy_cnt=0. Next req_valid=11 grants requester 0.
- Idle: req_valid=00 for 5 cycles -> rsp_valid stays 00, busy_cnt unchanged, last_grant unchanged.
